// File: rtl/rs232_rx_oversampled.sv
// rs232_rx_oversampled: 8N1 serial receiver, oversampled by CLKS_PER_BIT.
// The line is double-flopped into rxs_r. An arming phase, requiring one full
// bit-time of high line, runs after reset so that a reset released mid-frame
// cannot mistake data bits for a start bit. A start bit is qualified at
// mid-bit. Data and stop bits are then sampled one bit-time apart. A low stop
// bit parks the receiver in BREAK until the line returns high. RxD_idle
// reports a long run of high line independently of the frame FSM.
module rs232_rx_oversampled #(
    parameter int CLKS_PER_BIT = 16,
    parameter int IDLE_BITS    = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       RxD,
    output logic [7:0] Data,
    output logic       Valid,
    output logic       Error,
    output logic       RxD_idle,
    output logic       Busy
);

    localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_LIMIT);

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;

    logic              sync_meta_r;
    logic              rxs_r;
    logic [IDLE_W-1:0] idle_cnt_r;
    state_t            state_r;
    logic [CNT_W-1:0]  samp_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_meta_r <= 1'b1;
            rxs_r       <= 1'b1;
        end else begin
            sync_meta_r <= RxD;
            rxs_r       <= sync_meta_r;
        end
    end

    // Saturating run-length counter of high line; drives RxD_idle
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idle_cnt_r <= '0;
            RxD_idle   <= 1'b0;
        end else if (rxs_r) begin
            if (idle_cnt_r != IDLE_MAX) begin
                idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
            end else begin
                idle_cnt_r <= idle_cnt_r;
            end
            // The count after this edge reaches the limit when it is LIMIT-1 now
            RxD_idle <= (idle_cnt_r >= (IDLE_MAX - IDLE_W'(1)));
        end else begin
            idle_cnt_r <= '0;
            RxD_idle   <= 1'b0;
        end
    end

    // Frame FSM with registered Data/Valid/Error/Busy
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= ST_ARM;
            samp_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            Data       <= 8'h00;
            Valid      <= 1'b0;
            Error      <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Valid <= 1'b0;
            Error <= 1'b0;
            case (state_r)
                ST_ARM: begin
                    // Need CLKS_PER_BIT consecutive high samples before listening
                    if (!rxs_r) begin
                        samp_cnt_r <= '0;
                        Busy       <= 1'b1;
                    end else if (samp_cnt_r == BIT_LAST) begin
                        samp_cnt_r <= '0;
                        state_r    <= ST_IDLE;
                        Busy       <= 1'b0;
                    end else begin
                        samp_cnt_r <= samp_cnt_r + CNT_W'(1);
                        Busy       <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!rxs_r) begin
                        state_r    <= ST_START;
                        samp_cnt_r <= '0;
                        bit_cnt_r  <= 3'd0;
                        Busy       <= 1'b1;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                ST_START: begin
                    // Qualify the start bit at its midpoint
                    if (samp_cnt_r == HALF_LAST) begin
                        samp_cnt_r <= '0;
                        if (rxs_r) begin
                            state_r <= ST_IDLE;
                            Busy    <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                            Busy    <= 1'b1;
                        end
                    end else begin
                        samp_cnt_r <= samp_cnt_r + CNT_W'(1);
                        Busy       <= 1'b1;
                    end
                end
                ST_DATA: begin
                    Busy <= 1'b1;
                    if (samp_cnt_r == BIT_LAST) begin
                        samp_cnt_r <= '0;
                        shift_r    <= {rxs_r, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        samp_cnt_r <= samp_cnt_r + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (samp_cnt_r == BIT_LAST) begin
                        samp_cnt_r <= '0;
                        if (rxs_r) begin
                            Data    <= shift_r;
                            Valid   <= 1'b1;
                            state_r <= ST_IDLE;
                            Busy    <= 1'b0;
                        end else begin
                            Error   <= 1'b1;
                            state_r <= ST_BREAK;
                            Busy    <= 1'b1;
                        end
                    end else begin
                        samp_cnt_r <= samp_cnt_r + CNT_W'(1);
                        Busy       <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Held low line: wait for it to return high before listening
                    if (rxs_r) begin
                        state_r <= ST_IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        Busy <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_ARM;
                    samp_cnt_r <= '0;
                    Busy       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_rx_oversampled.sv
// Self-checking bench for rs232_rx_oversampled. A frame-level model predicts
// outputs from the recorded line history using bit-time arithmetic.
module tb_rs232_rx_oversampled;

    localparam int CPB       = 16;
    localparam int IDLE_BITS = 10;
    localparam int H         = CPB / 2;
    localparam int LIMIT     = IDLE_BITS * CPB;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       RxD;
    logic [7:0] Data;
    logic       Valid, Error, RxD_idle, Busy;

    int errors = 0;
    int checks = 0;

    rs232_rx_oversampled #(.CLKS_PER_BIT(CPB), .IDLE_BITS(IDLE_BITS)) dut (
        .Clk(Clk), .Reset(Reset), .RxD(RxD), .Data(Data), .Valid(Valid),
        .Error(Error), .RxD_idle(RxD_idle), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_ARM, M_READY, M_FRAME, M_BREAK} mmode_t;
    int         n        = 0;     // index of the most recent rising edge
    int         last_rst = -10;   // last edge seen with Reset high
    int         run      = 0;     // consecutive high synchronized samples
    int         fs       = 0;     // edge at which the start bit was first seen
    mmode_t     mode     = M_ARM;
    logic       hist [256];       // RxD as sampled at each edge
    logic [7:0] m_data   = 8'h00;
    logic       m_valid  = 1'b0, m_err = 1'b0, m_idle = 1'b0, m_busy = 1'b0;

    // Synchronized line seen by the logic at edge m: RxD two edges earlier,
    // or high while the synchronizer still holds its reset value.
    function automatic logic rxs_at(input int m);
        if (m - 2 <= last_rst) return 1'b1;
        return hist[(m - 2) % 256];
    endfunction

    // Model update at each rising edge: outputs expected after that edge
    always @(posedge Clk) begin
        logic       r;
        int         t;
        logic [7:0] b;
        n++;
        hist[n % 256] = RxD;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (Reset) begin
            last_rst = n; mode = M_ARM; run = 0;
            m_data = 8'h00; m_idle = 1'b0; m_busy = 1'b0;
        end else begin
            r = rxs_at(n);
            run = r ? run + 1 : 0;
            m_idle = (run >= LIMIT);
            case (mode)
                M_ARM:   if (run >= CPB) mode = M_READY;
                M_READY: if (!r) begin mode = M_FRAME; fs = n; end
                M_FRAME: begin
                    t = n - fs;
                    if (t == H && r) mode = M_READY;
                    else if (t == H + 9 * CPB) begin
                        if (r) begin
                            b = 8'h00;
                            for (int k = 0; k < 8; k++) b[k] = rxs_at(fs + H + (k + 1) * CPB);
                            m_data = b; m_valid = 1'b1; mode = M_READY;
                        end else begin
                            m_err = 1'b1; mode = M_BREAK;
                        end
                    end
                end
                M_BREAK: if (r) mode = M_READY;
                default: mode = M_ARM;
            endcase
            m_busy = (mode != M_READY);
        end
    end

    // ---------------- compare and event monitor ----------------
    int         valid_cnt = 0, err_cnt = 0, last_valid_n = 0;
    logic [7:0] data_q [$];

    // Compare DUT against model every cycle on the falling edge
    always @(negedge Clk) begin
        if (Reset) begin
            check("rst_data", Data, 32'h0);
            check("rst_valid", Valid, 32'h0);
            check("rst_error", Error, 32'h0);
            check("rst_idle", RxD_idle, 32'h0);
            check("rst_busy", Busy, 32'h0);
        end else begin
            check("data", Data, m_data);
            check("valid", Valid, m_valid);
            check("error", Error, m_err);
            check("rxd_idle", RxD_idle, m_idle);
            check("busy", Busy, m_busy);
        end
        if (Valid) begin valid_cnt++; last_valid_n = n; data_q.push_back(Data); end
        if (Error) err_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k);
        repeat (k) begin @(posedge Clk); #1; end
    endtask

    task automatic send_bits(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 8; i++) begin RxD = b[i]; tick(CPB); end
        RxD = stop; tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        RxD = 1'b0; tick(CPB);
        send_bits(b, stop);
    endtask

    initial begin
        int k, n0, v0, e0, qs, sel;
        Reset = 1'b1; RxD = 1'b1;
        tick(3);
        Reset = 1'b0;

        // RxD_idle rises 160 cycles after release with the line high
        k = 0;
        while (!RxD_idle && k < 300) begin tick(1); k++; end
        check("idle_rise_cycle", k, 32'd160);
        tick(20 * CPB - k);

        // Frame 0xA5; RxD_idle drops the cycle after rxs goes low
        v0 = valid_cnt; e0 = err_cnt;
        RxD = 1'b0; n0 = n;
        tick(2); check("idle_hold", RxD_idle, 32'd1);
        tick(1); check("idle_clear", RxD_idle, 32'd0);
        tick(CPB - 3);
        send_bits(8'hA5, 1'b1);
        RxD = 1'b1; tick(CPB);
        check("a5_valid_count", valid_cnt - v0, 32'd1);
        check("a5_latency", last_valid_n - (n0 + 1), 32'd154);
        check("a5_data", Data, 32'hA5);
        check("a5_model", m_data, 32'hA5);
        check("a5_no_error", err_cnt - e0, 32'd0);

        // Short glitch: rejected as start bit
        v0 = valid_cnt; e0 = err_cnt;
        RxD = 1'b0; tick(4); RxD = 1'b1; tick(3 * CPB);
        check("glitch_valid", valid_cnt - v0, 32'd0);
        check("glitch_error", err_cnt - e0, 32'd0);
        check("glitch_data", Data, 32'hA5);
        check("glitch_busy", Busy, 32'd0);

        // Framing error, break, then good frame
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        RxD = 1'b0; tick(3 * CPB);
        check("ferr_count", err_cnt - e0, 32'd1);
        check("ferr_data", Data, 32'hA5);
        check("ferr_no_valid", valid_cnt - v0, 32'd0);
        check("break_busy", Busy, 32'd1);
        RxD = 1'b1; tick(2 * CPB);
        send_frame(8'h0F, 1'b1);
        RxD = 1'b1; tick(CPB);
        check("after_break_valid", valid_cnt - v0, 32'd1);
        check("after_break_data", Data, 32'h0F);

        // Back-to-back frames with one stop bit
        qs = data_q.size(); e0 = err_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        RxD = 1'b1; tick(2 * CPB);
        check("b2b_count", data_q.size() - qs, 32'd2);
        if (data_q.size() >= qs + 2) begin
            check("b2b_first", data_q[qs], 32'h00);
            check("b2b_second", data_q[qs + 1], 32'hFF);
        end
        check("b2b_no_error", err_cnt - e0, 32'd0);

        // Reset during data bit 4 with the line low
        v0 = valid_cnt; e0 = err_cnt;
        RxD = 1'b0; tick(5 * CPB + H);
        Reset = 1'b1; tick(5);
        check("midrst_data", Data, 32'h00);
        Reset = 1'b0; tick(2 * CPB);
        check("midrst_no_valid", valid_cnt - v0, 32'd0);
        check("midrst_no_error", err_cnt - e0, 32'd0);
        check("midrst_arm_busy", Busy, 32'd1);
        RxD = 1'b1; tick(CPB);
        send_frame(8'h81, 1'b1);
        RxD = 1'b1; tick(CPB);
        check("midrst_valid", valid_cnt - v0, 32'd1);
        check("midrst_data81", Data, 32'h81);
        check("midrst_error", err_cnt - e0, 32'd0);

        // Randomized traffic checked by the per-cycle model compare
        for (int it = 0; it < 80; it++) begin
            sel = $urandom_range(0, 11);
            if (sel < 7) begin
                send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
            end else if (sel < 9) begin
                RxD = 1'b0; tick($urandom_range(1, H - 1)); RxD = 1'b1; tick(1);
            end else if (sel < 11) begin
                RxD = 1'b1; tick($urandom_range(1, 3 * CPB));
            end else begin
                Reset = 1'b1; tick($urandom_range(1, 4)); Reset = 1'b0;
            end
        end
        RxD = 1'b1; tick(12 * CPB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
